clk_en_gen: RTL and testbench

- Parametrised, multi-channel successor to the fixed power-of-two clock divider.
- Produces NCH independent single-cycle clock-enable ticks from one system clock.
- Each channel has its own divisor, which can be changed at run time. New divisors are applied glitch-free at the channel's next wrap.
- Consumers (VGA pixel enable, scan/refresh, game-step timers) gate logic with the ticks instead of using divided clocks as clocks.

---
 rtl/clk_en_gen_if.sv | 16 +
 rtl/clk_en_gen.sv | 172 +++++++++++++++++
 tb/tb_clk_en_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_gen_if.sv
// Divisor-write bus for clk_en_gen.
// The master drives run-time divisor updates and the slave (clk_en_gen) consumes them.
// wr_ch is wide enough to address every channel, with a minimum of 1 bit.
interface clk_en_gen_if #(
  parameter int NCH = 5,
  parameter int CW  = 32
);
  localparam int WCH = (NCH > 1) ? $clog2(NCH) : 1;

  logic           wr_en;
  logic [WCH-1:0] wr_ch;
  logic [CW-1:0]  wr_div;

  modport master (output wr_en, output wr_ch, output wr_div);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div);
endinterface

// File: rtl/clk_en_gen.sv
// clk_en_gen: NCH independent clock-enable tick generators with run-time divisors.
// Each channel counts 0..d-1, where d = max(div,1), and pulses tick for one cycle
// on the wrap. A written divisor is held in a shadow register (pend=1) and is
// applied at the channel's next wrap, so a period that is in progress always
// completes with the old d.
// Optional feature: define TOGGLE_OUT_EN to add the sq port. Each sq bit is a
// 50% square wave that toggles on every tick.
module clk_en_gen #(
  parameter int                NCH      = 5,
  parameter int                CW       = 32,
  parameter logic [NCH*CW-1:0] DIV_INIT = {32'd2000000, 32'd1000000, 32'd500000,
                                           32'd62500, 32'd4}
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           en,
  input  logic           sync,
  clk_en_gen_if.slave    wr_if,
  output logic [NCH-1:0] tick,
`ifdef TOGGLE_OUT_EN
  output logic [NCH-1:0] sq,
`endif
  output logic [NCH-1:0] pend
);

  localparam logic [CW-1:0] L_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] L_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // A divisor of zero behaves like a divisor of one.
  function automatic logic [CW-1:0] eff_div(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == L_ZERO) begin
      r = L_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [CW-1:0]  r_cnt    [NCH];
  logic [CW-1:0]  r_div    [NCH];
  logic [CW-1:0]  r_shadow [NCH];
  logic [NCH-1:0] r_tick;
  logic [NCH-1:0] r_pend;

  logic [CW-1:0]  w_cnt_nxt    [NCH];
  logic [CW-1:0]  w_div_nxt    [NCH];
  logic [CW-1:0]  w_shadow_nxt [NCH];
  logic [NCH-1:0] w_tick_nxt;
  logic [NCH-1:0] w_pend_nxt;
  logic [NCH-1:0] w_wr_hit;
  logic [31:0]    w_wr_idx;

`ifdef TOGGLE_OUT_EN
  logic [NCH-1:0] r_sq;
  logic [NCH-1:0] w_sq_nxt;
`endif

  assign w_wr_idx = 32'(wr_if.wr_ch);

  // Decode the write strobe per channel. An index of NCH or above matches no channel.
  always_comb begin
    w_wr_hit = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (wr_if.wr_en && (w_wr_idx == 32'(i))) begin
        w_wr_hit[i] = 1'b1;
      end else begin
        w_wr_hit[i] = 1'b0;
      end
    end
  end

  // Per-channel next state. Priority is sync, then freeze (en=0), then wrap, then count.
  always_comb begin
    w_tick_nxt = {NCH{1'b0}};
    w_pend_nxt = r_pend;
`ifdef TOGGLE_OUT_EN
    w_sq_nxt   = r_sq;
`endif
    for (int i = 0; i < NCH; i++) begin
      w_cnt_nxt[i]    = r_cnt[i];
      w_div_nxt[i]    = r_div[i];
      w_shadow_nxt[i] = r_shadow[i];
      if (sync) begin
        // Restart in phase. A write in this cycle bypasses the shadow and lands in div.
        w_cnt_nxt[i]  = L_ZERO;
        w_pend_nxt[i] = 1'b0;
`ifdef TOGGLE_OUT_EN
        w_sq_nxt[i]   = 1'b0;
`endif
        if (w_wr_hit[i]) begin
          w_div_nxt[i]    = wr_if.wr_div;
          w_shadow_nxt[i] = wr_if.wr_div;
        end else if (r_pend[i]) begin
          w_div_nxt[i] = r_shadow[i];
        end else begin
          w_div_nxt[i] = r_div[i];
        end
      end else begin
        if (w_wr_hit[i]) begin
          w_shadow_nxt[i] = wr_if.wr_div;
        end else begin
          w_shadow_nxt[i] = r_shadow[i];
        end
        if (!en) begin
          // Frozen: apply any waiting divisor now and keep cnt inside the new range.
          w_pend_nxt[i] = w_wr_hit[i];
          if (r_pend[i]) begin
            w_div_nxt[i] = r_shadow[i];
            if (r_cnt[i] >= eff_div(r_shadow[i])) begin
              w_cnt_nxt[i] = L_ZERO;
            end else begin
              w_cnt_nxt[i] = r_cnt[i];
            end
          end else begin
            w_div_nxt[i] = r_div[i];
          end
        end else if (r_cnt[i] == (eff_div(r_div[i]) - L_ONE)) begin
          // Wrap: the old shadow is applied, and a write in this same cycle stays pending.
          w_cnt_nxt[i]  = L_ZERO;
          w_tick_nxt[i] = 1'b1;
          w_pend_nxt[i] = w_wr_hit[i];
`ifdef TOGGLE_OUT_EN
          w_sq_nxt[i]   = ~r_sq[i];
`endif
          if (r_pend[i]) begin
            w_div_nxt[i] = r_shadow[i];
          end else begin
            w_div_nxt[i] = r_div[i];
          end
        end else begin
          w_cnt_nxt[i]  = r_cnt[i] + L_ONE;
          w_pend_nxt[i] = r_pend[i] | w_wr_hit[i];
        end
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]    <= L_ZERO;
        r_div[i]    <= DIV_INIT[i*CW +: CW];
        r_shadow[i] <= DIV_INIT[i*CW +: CW];
      end
      r_tick <= {NCH{1'b0}};
      r_pend <= {NCH{1'b0}};
`ifdef TOGGLE_OUT_EN
      r_sq   <= {NCH{1'b0}};
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]    <= w_cnt_nxt[i];
        r_div[i]    <= w_div_nxt[i];
        r_shadow[i] <= w_shadow_nxt[i];
      end
      r_tick <= w_tick_nxt;
      r_pend <= w_pend_nxt;
`ifdef TOGGLE_OUT_EN
      r_sq   <= w_sq_nxt;
`endif
    end
  end

  assign tick = r_tick;
  assign pend = r_pend;
`ifdef TOGGLE_OUT_EN
  assign sq   = r_sq;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen. It uses small init divisors so that every scenario
// finishes in a few cycles: ch0=4, ch1=6, ch2=3, ch3=5, ch4=0 (which behaves as 1).
// sq is checked only when TOGGLE_OUT_EN is defined.
module tb_clk_en_gen;
  localparam int NCH = 5;
  localparam int CW  = 32;
  localparam logic [NCH*CW-1:0] INIT = {32'd0, 32'd5, 32'd3, 32'd6, 32'd4};

  logic           clk   = 1'b0;
  logic           clr_n = 1'b0;
  logic           en    = 1'b0;
  logic           sync  = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;
`ifdef TOGGLE_OUT_EN
  logic [NCH-1:0] sq;
`endif

  int n_vec = 0;
  int n_err = 0;

  int d_a [NCH] = '{4, 6, 3, 5, 1};
  int d_b [NCH] = '{4, 6, 5, 5, 1};

  clk_en_gen_if #(.NCH(NCH), .CW(CW)) wr_if ();

  clk_en_gen #(.NCH(NCH), .CW(CW), .DIV_INIT(INIT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (en),
    .sync  (sync),
    .wr_if (wr_if),
    .tick  (tick),
`ifdef TOGGLE_OUT_EN
    .sq    (sq),
`endif
    .pend  (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic on, input logic [2:0] ch, input logic [31:0] v);
    wr_if.wr_en  = on;
    wr_if.wr_ch  = ch;
    wr_if.wr_div = v;
  endtask

  // Runs n edges after an in-phase start and checks the tick pattern (k % d == 0) and,
  // when sq is present, the square-wave level ((k / d) odd).
  task automatic run_phase(input string tag, input int d[NCH], input int n);
    logic [NCH-1:0] et;
    logic [NCH-1:0] es;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        et[i] = ((k % d[i]) == 0);
        es[i] = (((k / d[i]) % 2) == 1);
      end
      check(tag, 32'(tick), 32'(et));
`ifdef TOGGLE_OUT_EN
      check({tag, "_sq"}, 32'(sq), 32'(es));
`endif
    end
  endtask

  initial begin
    set_wr(1'b0, 3'd0, 32'd0);
    // Reset state: clr_n is held low for three edges.
    repeat (3) step();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
`ifdef TOGGLE_OUT_EN
    check("rst_sq", 32'(sq), 32'd0);
`endif
    // Scenario 1: free run from reset with the init divisors.
    clr_n = 1'b1;
    en    = 1'b1;
    run_phase("s1_run", d_a, 12);
    check("s1_pend", 32'(pend), 32'd0);

    // Sync clears tick and sq and restarts every counter.
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick", 32'(tick), 32'd0);
`ifdef TOGGLE_OUT_EN
    check("sync_sq", 32'(sq), 32'd0);
`endif

    // Scenario 2: write ch0=6 at cnt=1. It becomes pending and applies at the tick on edge 4.
    step();
    set_wr(1'b1, 3'd0, 32'd6);
    step();
    set_wr(1'b0, 3'd0, 32'd0);
    check("s2_pend_set", 32'(pend), 32'd1);
    check("s2_tick_e2", 32'(tick[0]), 32'd0);
    step();
    check("s2_pend_e3", 32'(pend[0]), 32'd1);
    step();
    check("s2_tick_e4", 32'(tick[0]), 32'd1);
    check("s2_pend_clr", 32'(pend[0]), 32'd0);
    for (int k = 5; k <= 16; k++) begin
      step();
      check("s2_new_period", 32'(tick[0]), 32'((k == 10) || (k == 16)));
    end

    // Scenario 3a / 5b: sync with a simultaneous write of 0. div is loaded directly, so ch0 ticks every cycle.
    sync = 1'b1;
    set_wr(1'b1, 3'd0, 32'd0);
    step();
    sync = 1'b0;
    set_wr(1'b0, 3'd0, 32'd0);
    check("s3_sync_wr_pend", 32'(pend), 32'd0);
    check("s3_sync_wr_tick", 32'(tick), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("s3_div0_tick", 32'(tick[0]), 32'd1);
    end

    // Scenario 3b: a write to channel 7 is ignored.
    set_wr(1'b1, 3'd7, 32'd9);
    step();
    set_wr(1'b0, 3'd0, 32'd0);
    check("s3_ch7_pend", 32'(pend), 32'd0);
    check("s3_ch7_tick", 32'(tick[0]), 32'd1);

    // Scenario 3c: a write to ch2 that coincides with its wrap stays pending for one more period.
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    step();
    check("s3c_pre_wrap", 32'(tick[2]), 32'd0);
    set_wr(1'b1, 3'd2, 32'd5);
    step();
    set_wr(1'b0, 3'd0, 32'd0);
    check("s3c_wrap_tick", 32'(tick[2]), 32'd1);
    check("s3c_wrap_pend", 32'(pend[2]), 32'd1);
    step();
    step();
    check("s3c_pend_hold", 32'(pend[2]), 32'd1);
    step();
    check("s3c_old_d_tick", 32'(tick[2]), 32'd1);
    check("s3c_pend_clr", 32'(pend[2]), 32'd0);
    for (int k = 7; k <= 11; k++) begin
      step();
      check("s3c_new_d", 32'(tick[2]), 32'(k == 11));
    end

    // Scenario 4: a write made while frozen is applied before the restart. Freeze at cnt=2 holds the counter.
    en = 1'b0;
    set_wr(1'b1, 3'd0, 32'd4);
    step();
    set_wr(1'b0, 3'd0, 32'd0);
    check("s4_frz_wr_pend", 32'(pend[0]), 32'd1);
    check("s4_frz_tick", 32'(tick), 32'd0);
    step();
    check("s4_frz_apply", 32'(pend[0]), 32'd0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    en   = 1'b1;
    step();
    step();
    check("s4_cnt2", 32'(tick[0]), 32'd0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("s4_freeze", 32'(tick), 32'd0);
    end
    en = 1'b1;
    step();
    check("s4_resume1", 32'(tick[0]), 32'd0);
    step();
    check("s4_resume2", 32'(tick[0]), 32'd1);
    // Freeze at cnt=2 and write d=2. On apply, cnt is clamped to 0.
    step();
    step();
    en = 1'b0;
    set_wr(1'b1, 3'd0, 32'd2);
    step();
    set_wr(1'b0, 3'd0, 32'd0);
    check("s4_clamp_pend", 32'(pend[0]), 32'd1);
    step();
    check("s4_clamp_apply", 32'(pend[0]), 32'd0);
    en = 1'b1;
    step();
    check("s4_clamp_e1", 32'(tick[0]), 32'd0);
    step();
    check("s4_clamp_e2", 32'(tick[0]), 32'd1);

    // Scenario 5: sync together with a write of ch0=4. All channels then run in phase.
    sync = 1'b1;
    set_wr(1'b1, 3'd0, 32'd4);
    step();
    sync = 1'b0;
    set_wr(1'b0, 3'd0, 32'd0);
    check("s5_sync_pend", 32'(pend), 32'd0);
    check("s5_sync_tick", 32'(tick), 32'd0);
    run_phase("s5_phase", d_b, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
